button_bus_wrapper: RTL and testbench
=====================================

BUTTON_BUS_WRAPPER -- requirements
Module: button_bus_wrapper

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h80: bus address of register 0; occupies BASE_ADDR..BASE_ADDR+2.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: stable-input cycles required before an input is accepted (10 ms at 100 MHz).
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port BUS_DATA  inout  8  shared data bus; driven only during its own reads, else high-Z.
REQ-006 SHALL have port BUS_ADDR  input  8  bus address.
REQ-007 SHALL have port BUS_WE  input  1  bus write enable, 1 = write.
REQ-008 SHALL have port Push_button  input  4  raw asynchronous push buttons.
REQ-009 SHALL have port Switch_in  input  2  raw asynchronous slide switches.
REQ-010 SHALL have port BUS_INTERRUPT_RAISE  output  1  level interrupt request to processor.
REQ-011 SHALL have port BUS_INTERRUPT_ACK  input  1  one-cycle acknowledge from processor.

Function
REQ-012 SHALL pass each of the 6 raw inputs through a 2-flop synchroniser before debouncing.
REQ-013 SHALL, per input, count consecutive cycles where synchronised value differs from stable value; counter clears whenever they match.
REQ-014 SHALL update the stable value on the edge where the count reaches DEBOUNCE_CYCLES-1; input-to-stable latency exactly DEBOUNCE_CYCLES+2 cycles.
REQ-015 SHALL restart the count from 0 on any bounce (sync returns to stable value) before acceptance.
REQ-016 SHALL expose STATUS at BASE_ADDR: bits [3:0] stable buttons, [5:4] stable switches, [7:6] read 0.
REQ-017 SHALL expose EDGE at BASE_ADDR+1: bit n (n=0..3) set sticky when stable button n goes 0->1, in the same cycle the stable value updates.
REQ-018 SHALL clear EDGE bits by bus write of 1 to those bits (write-1-to-clear); writing 0 has no effect.
REQ-019 SHALL keep an EDGE bit at 1 when a clearing write and a new edge on that bit coincide.
REQ-020 SHALL expose IRQ_EN at BASE_ADDR+2, read/write, 8 bits, bit-for-bit mask over EDGE.
REQ-021 SHALL drive read data one cycle after BUS_ADDR matches with BUS_WE=0, held while the match persists; BUS_DATA is high-Z the cycle after a non-match or write.
REQ-022 SHALL ignore writes to STATUS and all accesses outside BASE_ADDR..BASE_ADDR+2.
REQ-023 SHALL set BUS_INTERRUPT_RAISE on the cycle after any EDGE bit transitions 0->1 with its IRQ_EN bit set; hold it until BUS_INTERRUPT_ACK.
REQ-024 SHALL clear BUS_INTERRUPT_RAISE on the cycle after ACK, unless a new enabled edge arrives in the ACK cycle, in which case it stays 1.
REQ-025 SHALL not raise an interrupt for edges already pending when IRQ_EN is later set.

Reset
REQ-026 SHALL on RESET=0 immediately clear synchronisers, counters, stable values, EDGE, IRQ_EN and BUS_INTERRUPT_RAISE, and release BUS_DATA to high-Z.
REQ-027 SHALL treat inputs already high at reset release as new presses after DEBOUNCE_CYCLES+2 cycles.

Configuration
REQ-028 SHALL, with BUTTON_RELEASE_EDGE_EN defined, set EDGE bits [7:4] sticky on stable button 1->0 transitions, with identical clear/mask/interrupt rules.
REQ-029 SHALL, without BUTTON_RELEASE_EDGE_EN, read EDGE[7:4] as 0 and contain no release-detect logic.

Structure
REQ-030 SHALL place register offsets (STATUS=0, EDGE=1, IRQ_EN=2), input count (6) and default base address in a shared package button_pkg.
REQ-031 SHALL implement sync+counter+stable value as sub-module button_debouncer, instantiated 6 times.

Verification (DEBOUNCE_CYCLES=16)
REQ-032 SHALL check: Push_button[0] 0->1 clean -> STATUS=8'h01 exactly 18 cycles later, EDGE=8'h01.
REQ-033 SHALL check: Push_button[1] toggles every 5 cycles for 40 cycles then held 1 -> STATUS bit 1 rises exactly 18 cycles after final toggle, single EDGE set.
REQ-034 SHALL check: IRQ_EN=8'h04, press button 2 -> RAISE=1; ACK pulse -> RAISE=0 next cycle; press button 3 -> RAISE stays 0.
REQ-035 SHALL check: write 8'h01 to EDGE in same cycle button 0 re-accepts press -> EDGE[0] reads 1.
REQ-036 SHALL check: RESET=0 mid-count (8 cycles into debounce) -> all registers 0, BUS_DATA high-Z; press re-accepted 18 cycles after release.
REQ-037 SHALL check: with BUTTON_RELEASE_EDGE_EN, press/release button 0 -> EDGE=8'h11; without, EDGE=8'h01.

Source files
------------

// File: rtl/button_pkg.sv
// Register map, input count and default base address shared by the button bus wrapper.
package button_pkg;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_EDGE   = 2'd1,
    REG_IRQ_EN = 2'd2
  } reg_off_e;

  localparam int         NUM_INPUTS        = 6;
  localparam int         NUM_BUTTONS       = 4;
  localparam logic [7:0] NUM_REGS          = 8'd3;
  localparam logic [7:0] DEFAULT_BASE_ADDR = 8'h80;

  // Offset of a bus address from the block base; wraps so the window check is a single compare.
  function automatic logic [7:0] reg_offset(input logic [7:0] addr, input logic [7:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One raw input: two-flop synchroniser followed by a consecutive-mismatch counter.
// accept_o pulses in the cycle before stable_o flips to the synchronised value.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o,
  output logic accept_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mismatch;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any cycle where the input agrees with the stable value restarts the count.
  always_comb begin
    mismatch = (sync2_q != stable_q);
    accept_o = mismatch && (cnt_q == CNT_LAST);
    stable_d = stable_q;
    cnt_d    = '0;
    if (accept_o) begin
      stable_d = sync2_q;
    end else if (mismatch) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/button_bus_wrapper.sv
// Bus peripheral for 4 push buttons and 2 switches: STATUS, sticky W1C EDGE, IRQ_EN mask, level IRQ.
// Define BUTTON_RELEASE_EDGE_EN to also latch button release edges into EDGE[7:4].
module button_bus_wrapper
  import button_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int         DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [3:0] Push_button,
  input  logic [1:0] Switch_in,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  logic [NUM_INPUTS-1:0] raw, stable, accept;
  logic [7:0]            edge_q, edge_d;
  logic [7:0]            irq_en_q, irq_en_d;
  logic [7:0]            set_mask, clr_mask, rd_data, offset;
  logic                  raise_q, raise_d;
  logic                  rd_en_q, rd_en_d;
  logic                  hit;
  reg_off_e              rd_sel_q, rd_sel_d;

  assign raw = {Switch_in, Push_button};

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_deb
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i   (CLK),
      .rst_ni  (RESET),
      .raw_i   (raw[g]),
      .stable_o(stable[g]),
      .accept_o(accept[g])
    );
  end

  // An accept strobe means stable is about to invert, so the current stable value gives the direction.
  always_comb begin
    set_mask                = '0;
    set_mask[NUM_BUTTONS-1:0] = accept[NUM_BUTTONS-1:0] & ~stable[NUM_BUTTONS-1:0];
`ifdef BUTTON_RELEASE_EDGE_EN
    set_mask[7:4]           = accept[NUM_BUTTONS-1:0] & stable[NUM_BUTTONS-1:0];
`endif
  end

  always_comb begin
    offset   = reg_offset(BUS_ADDR, BASE_ADDR);
    hit      = (offset < NUM_REGS);
    rd_en_d  = hit && !BUS_WE;
    rd_sel_d = reg_off_e'(offset[1:0]);
    clr_mask = '0;
    irq_en_d = irq_en_q;
    if (hit && BUS_WE) begin
      case (rd_sel_d)
        REG_EDGE:   clr_mask = BUS_DATA;
        REG_IRQ_EN: irq_en_d = BUS_DATA;
        default:    ;
      endcase
    end
    // Set wins over a coincident clear; only fresh 0->1 transitions under the mask raise the IRQ.
    edge_d  = (edge_q & ~clr_mask) | set_mask;
    raise_d = (|(set_mask & ~edge_q & irq_en_q)) | (raise_q & ~BUS_INTERRUPT_ACK);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      edge_q   <= '0;
      irq_en_q <= '0;
      raise_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      rd_sel_q <= REG_STATUS;
    end else begin
      edge_q   <= edge_d;
      irq_en_q <= irq_en_d;
      raise_q  <= raise_d;
      rd_en_q  <= rd_en_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  always_comb begin
    case (rd_sel_q)
      REG_STATUS: rd_data = {2'b00, stable};
      REG_EDGE:   rd_data = edge_q;
      REG_IRQ_EN: rd_data = irq_en_q;
      default:    rd_data = 8'h00;
    endcase
  end

  assign BUS_DATA            = rd_en_q ? rd_data : 8'hzz;
  assign BUS_INTERRUPT_RAISE = raise_q;

endmodule

// File: tb/tb_button_bus_wrapper.sv
// Self-checking bench for button_bus_wrapper with DEBOUNCE_CYCLES=16; honours BUTTON_RELEASE_EDGE_EN.
module tb_button_bus_wrapper;

  localparam int         N    = 16;
  localparam logic [7:0] BASE = 8'h80;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  wire  [7:0] BUS_DATA;
  logic [7:0] BUS_ADDR = 8'h00;
  logic       BUS_WE = 1'b0;
  logic [3:0] Push_button = 4'h0;
  logic [1:0] Switch_in = 2'b00;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK = 1'b0;
  logic       drv = 1'b0;
  logic [7:0] wdata = 8'h00;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [5:0] m_stable;
  logic [7:0] m_edge, m_irq;
  logic       m_raise;
  logic [5:0] hist [0:N+1];

  assign BUS_DATA = drv ? wdata : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (BUS_DATA[g]);
  end

  always #5 CLK = ~CLK;

  button_bus_wrapper #(
    .BASE_ADDR      (BASE),
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .BUS_DATA           (BUS_DATA),
    .BUS_ADDR           (BUS_ADDR),
    .BUS_WE             (BUS_WE),
    .Push_button        (Push_button),
    .Switch_in          (Switch_in),
    .BUS_INTERRUPT_RAISE(BUS_INTERRUPT_RAISE),
    .BUS_INTERRUPT_ACK  (BUS_INTERRUPT_ACK)
  );

  task automatic model_clear();
    m_stable = '0;
    m_edge   = '0;
    m_irq    = '0;
    m_raise  = 1'b0;
    for (int k = 0; k <= N + 1; k++) hist[k] = '0;
  endtask

  // An input is accepted once its last N synchronised samples all disagree with the accepted value.
  task automatic model_edge();
    logic [5:0] nst;
    logic [7:0] setm, clr;
    logic       all_diff;
    if (!RESET) begin
      model_clear();
    end else begin
      for (int k = N + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {Switch_in, Push_button};
      nst = m_stable;
      for (int i = 0; i < 6; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < N; j++) if (hist[j+2][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) nst[i] = ~m_stable[i];
      end
      setm      = 8'h00;
      setm[3:0] = nst[3:0] & ~m_stable[3:0];
`ifdef BUTTON_RELEASE_EDGE_EN
      setm[7:4] = ~nst[3:0] & m_stable[3:0];
`endif
      clr     = (BUS_WE && BUS_ADDR == BASE + 8'd1) ? wdata : 8'h00;
      m_raise = (|(setm & ~m_edge & m_irq)) || (m_raise && !BUS_INTERRUPT_ACK);
      m_edge  = (m_edge & ~clr) | setm;
      if (BUS_WE && BUS_ADDR == BASE + 8'd2) m_irq = wdata;
      m_stable = nst;
    end
  endtask

  function automatic logic [7:0] model_reg(input int o);
    case (o)
      0:       return {2'b00, m_stable};
      1:       return m_edge;
      2:       return m_irq;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = 8'h00; BUS_WE = 1'b0; drv = 1'b0;
    tick();
    BUS_ADDR = a; BUS_WE = 1'b1; wdata = d; drv = 1'b1;
    tick();
    BUS_ADDR = 8'h00; BUS_WE = 1'b0; drv = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    BUS_ADDR = a; BUS_WE = 1'b0; drv = 1'b0;
    tick();
    d = BUS_DATA;
    BUS_ADDR = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    BUS_ADDR = BASE;
    model_clear();
    ticks(2);
    checks++;
    if (BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL reset_raise: got %b expected 0", BUS_INTERRUPT_RAISE);
    end
    checks++;
    if (BUS_DATA !== 8'hFF) begin
      errors++; $display("FAIL reset_bus_hiz: got %h expected released (pulled FF)", BUS_DATA);
    end
    RESET = 1'b1;
    for (int o = 0; o < 3; o++) begin
      bus_read(BASE + 8'(o), d);
      checks++;
      if (d !== 8'h00) begin
        errors++; $display("FAIL reset_reg%0d: got %h expected 00", o, d);
      end
    end
  endtask

  task automatic test_press_clean();
    logic [7:0] d;
    BUS_ADDR = BASE;
    tick();
    Push_button[0] = 1'b1;
    ticks(N + 1);
    checks++;
    if (BUS_DATA !== 8'h00) begin
      errors++; $display("FAIL press_early: got %h expected 00 at cycle 17", BUS_DATA);
    end
    tick();
    checks++;
    if (BUS_DATA !== 8'h01) begin
      errors++; $display("FAIL press_status: got %h expected 01 at cycle 18", BUS_DATA);
    end
    bus_read(BASE + 8'd1, d);
    checks++;
    if (d !== 8'h01) begin
      errors++; $display("FAIL press_edge: got %h expected 01", d);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] d;
    bus_write(BASE + 8'd1, 8'hFF);
    BUS_ADDR = BASE;
    tick();
    for (int t = 0; t <= 40; t++) begin
      if (t % 5 == 0) Push_button[1] = ~Push_button[1];
      if (t < 40) tick();
    end
    ticks(N + 1);
    checks++;
    if (BUS_DATA !== 8'h01) begin
      errors++; $display("FAIL bounce_early: got %h expected 01", BUS_DATA);
    end
    tick();
    checks++;
    if (BUS_DATA !== 8'h03) begin
      errors++; $display("FAIL bounce_accept: got %h expected 03", BUS_DATA);
    end
    bus_read(BASE + 8'd1, d);
    checks++;
    if (d !== 8'h02) begin
      errors++; $display("FAIL bounce_edge: got %h expected 02", d);
    end
  endtask

  task automatic test_irq();
    logic [7:0] d;
    bus_write(BASE + 8'd1, 8'hFF);
    bus_write(BASE + 8'd2, 8'h04);
    Push_button[2] = 1'b1;
    ticks(N + 1);
    checks++;
    if (BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL irq_early: got %b expected 0", BUS_INTERRUPT_RAISE);
    end
    tick();
    checks++;
    if (BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++; $display("FAIL irq_raise: got %b expected 1", BUS_INTERRUPT_RAISE);
    end
    tick();
    checks++;
    if (BUS_INTERRUPT_RAISE !== 1'b1) begin
      errors++; $display("FAIL irq_hold: got %b expected 1", BUS_INTERRUPT_RAISE);
    end
    BUS_INTERRUPT_ACK = 1'b1;
    tick();
    BUS_INTERRUPT_ACK = 1'b0;
    checks++;
    if (BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL irq_ack: got %b expected 0", BUS_INTERRUPT_RAISE);
    end
    Push_button[3] = 1'b1;
    ticks(N + 4);
    checks++;
    if (BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL irq_masked: got %b expected 0", BUS_INTERRUPT_RAISE);
    end
    bus_read(BASE + 8'd1, d);
    checks++;
    if (d !== 8'h0C) begin
      errors++; $display("FAIL irq_edge: got %h expected 0C", d);
    end
    bus_write(BASE + 8'd2, 8'h08);
    ticks(3);
    checks++;
    if (BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL irq_pending_enable: got %b expected 0", BUS_INTERRUPT_RAISE);
    end
    bus_write(BASE + 8'd2, 8'h00);
  endtask

  task automatic test_w1c();
    logic [7:0] d;
    Push_button[0] = 1'b0;
    ticks(N + 4);
    bus_write(BASE + 8'd1, 8'hFF);
    bus_write(BASE, 8'hFF);
    bus_read(BASE, d);
    checks++;
    if (d !== 8'h0E) begin
      errors++; $display("FAIL status_write_ignored: got %h expected 0E", d);
    end
    bus_write(BASE + 8'd3, 8'hFF);
    bus_read(BASE + 8'd2, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL out_of_window_write: got %h expected 00", d);
    end
    bus_read(BASE + 8'd3, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++; $display("FAIL out_of_window_read: got %h expected released (pulled FF)", d);
    end
    bus_read(BASE - 8'd1, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++; $display("FAIL below_window_read: got %h expected released (pulled FF)", d);
    end
    tick();
    Push_button[0] = 1'b1;
    ticks(N + 1);
    BUS_ADDR = BASE + 8'd1; BUS_WE = 1'b1; wdata = 8'h01; drv = 1'b1;
    tick();
    BUS_ADDR = 8'h00; BUS_WE = 1'b0; drv = 1'b0;
    bus_read(BASE + 8'd1, d);
    checks++;
    if (d[0] !== 1'b1) begin
      errors++; $display("FAIL w1c_coincide: got %h expected bit0 set", d);
    end
    bus_write(BASE + 8'd1, 8'h00);
    bus_read(BASE + 8'd1, d);
    checks++;
    if (d !== 8'h01) begin
      errors++; $display("FAIL w0_no_effect: got %h expected 01", d);
    end
    bus_write(BASE + 8'd1, 8'h01);
    bus_read(BASE + 8'd1, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL w1c_clear: got %h expected 00", d);
    end
  endtask

  task automatic test_reset_mid();
    Push_button = 4'h0;
    ticks(N + 4);
    bus_write(BASE + 8'd2, 8'hFF);
    BUS_ADDR = BASE;
    tick();
    Push_button[2] = 1'b1;
    ticks(8);
    #1;
    RESET = 1'b0;
    model_clear();
    #1;
    checks++;
    if (BUS_DATA !== 8'hFF || BUS_INTERRUPT_RAISE !== 1'b0) begin
      errors++; $display("FAIL reset_async: got bus %h raise %b expected FF/0", BUS_DATA, BUS_INTERRUPT_RAISE);
    end
    ticks(2);
    RESET = 1'b1;
    BUS_ADDR = BASE + 8'd2;
    tick();
    checks++;
    if (BUS_DATA !== 8'h00) begin
      errors++; $display("FAIL reset_irq_en: got %h expected 00", BUS_DATA);
    end
    BUS_ADDR = BASE + 8'd1;
    tick();
    checks++;
    if (BUS_DATA !== 8'h00) begin
      errors++; $display("FAIL reset_edge: got %h expected 00", BUS_DATA);
    end
    BUS_ADDR = BASE;
    ticks(N - 1);
    checks++;
    if (BUS_DATA !== 8'h00) begin
      errors++; $display("FAIL reset_status_early: got %h expected 00", BUS_DATA);
    end
    tick();
    checks++;
    if (BUS_DATA !== 8'h04) begin
      errors++; $display("FAIL reset_reaccept: got %h expected 04", BUS_DATA);
    end
    BUS_ADDR = 8'h00;
  endtask

  task automatic test_release_edge();
    logic [7:0] d;
    logic [7:0] exp;
    bus_write(BASE + 8'd1, 8'hFF);
    Push_button[0] = 1'b1;
    ticks(N + 4);
    Push_button[0] = 1'b0;
    ticks(N + 4);
    bus_read(BASE + 8'd1, d);
`ifdef BUTTON_RELEASE_EDGE_EN
    exp = 8'h11;
`else
    exp = 8'h01;
`endif
    checks++;
    if (d !== exp) begin
      errors++; $display("FAIL release_edge: got %h expected %h", d, exp);
    end
  endtask

  task automatic test_random();
    int hold [6];
    int op, off;
    logic prev_read;
    logic [7:0] exp;
    prev_read = 1'b0;
    for (int i = 0; i < 6; i++) hold[i] = $urandom_range(1, 40);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 6; i++) begin
        if (hold[i] == 0) begin
          if (i < 4) Push_button[i] = ~Push_button[i];
          else       Switch_in[i-4] = ~Switch_in[i-4];
          hold[i] = $urandom_range(1, 40);
        end else begin
          hold[i]--;
        end
      end
      op  = $urandom_range(0, 7);
      off = $urandom_range(0, 3);
      if (op >= 5 && op <= 6 && prev_read) op = 7;
      BUS_WE = 1'b0; drv = 1'b0; BUS_ADDR = 8'h00;
      if (op <= 4) begin
        BUS_ADDR = BASE + 8'(off);
      end else if (op == 5) begin
        BUS_ADDR = BASE + 8'd1; BUS_WE = 1'b1; drv = 1'b1; wdata = 8'($urandom);
      end else if (op == 6) begin
        BUS_ADDR = BASE + 8'd2; BUS_WE = 1'b1; drv = 1'b1; wdata = 8'($urandom);
      end
      BUS_INTERRUPT_ACK = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (BUS_INTERRUPT_RAISE !== m_raise) begin
        errors++; $display("FAIL rand_raise c%0d: got %b expected %b", c, BUS_INTERRUPT_RAISE, m_raise);
      end
      if (op <= 4) begin
        exp = model_reg(off);
        checks++;
        if (BUS_DATA !== exp) begin
          errors++; $display("FAIL rand_read c%0d off%0d: got %h expected %h", c, off, BUS_DATA, exp);
        end
      end
      prev_read = (op <= 4) && (off < 3);
    end
    BUS_WE = 1'b0; drv = 1'b0; BUS_ADDR = 8'h00; BUS_INTERRUPT_ACK = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_press_clean();
    test_bounce();
    test_irq();
    test_w1c();
    test_reset_mid();
    test_release_edge();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
